// File: rtl/picomips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : picomips_pkg
// Description : Shared types and constants for the picoMIPS fetch path.
// Revision    : 1.0 - initial release
// ============================================================================
package picomips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam int unsigned PSIZE         = 5;
    localparam int unsigned ISIZE         = 16;
    localparam logic [15:0] HALT_WORD_DEF = 16'hFFFF;

endpackage : picomips_pkg
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_if
// Description : Fetch-side bundle: program memory, decode handshake, redirects.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if
    import picomips_pkg::*;
#(
    parameter int Psize = PSIZE,
    parameter int Isize = ISIZE
) ();

    logic             start;
    logic [Psize-1:0] pm_addr;
    logic [Isize-1:0] pm_instr;
    logic [Isize-1:0] instr;
    logic [Psize-1:0] instr_pc;
    logic             instr_valid;
    logic             instr_ready;
    logic             br_abs;
    logic             br_rel;
    logic [Psize-1:0] br_target;
    logic [Psize-1:0] br_offset;
    logic             halted;

    modport master (
        input  start, pm_instr, instr_ready, br_abs, br_rel, br_target, br_offset,
        output pm_addr, instr, instr_pc, instr_valid, halted
    );

    modport slave (
        output start, pm_instr, instr_ready, br_abs, br_rel, br_target, br_offset,
        input  pm_addr, instr, instr_pc, instr_valid, halted
    );

endinterface : fetch_ctrl_if
`default_nettype wire

// File: rtl/fetch_ctrl_pc_next.sv
`default_nettype none
// ============================================================================
// Module      : pc_next
// Description : Next-PC selection: absolute branch > relative branch > increment.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next
    import picomips_pkg::*;
#(
    parameter int Psize = PSIZE
) (
    input  logic [Psize-1:0] i_pc,
    input  logic [Psize-1:0] i_instr_pc,
    input  logic             i_br_abs,
    input  logic             i_br_rel,
    input  logic [Psize-1:0] i_br_target,
    input  logic [Psize-1:0] i_br_offset,
    input  logic             i_inc,
    output logic [Psize-1:0] o_pc_next,
    output logic             o_redirect
);

    // Psize-bit modular add equals sign-extend-then-truncate for the offset.
    always_comb begin
        o_pc_next  = i_pc;
        o_redirect = 1'b0;
        if (i_br_abs) begin
            o_pc_next  = i_br_target;
            o_redirect = 1'b1;
        end else if (i_br_rel) begin
            o_pc_next  = i_instr_pc + i_br_offset;
            o_redirect = 1'b1;
        end else if (i_inc) begin
            o_pc_next  = i_pc + 1'b1;
        end
    end

endmodule : pc_next
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : picoMIPS instruction-fetch sequencer with single-entry IR.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import picomips_pkg::*;
#(
    parameter int               Psize     = PSIZE,
    parameter int               Isize     = ISIZE,
    parameter logic [Isize-1:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic         clk,
    input  logic         n_reset,
    fetch_ctrl_if.master bus
);

    fetch_state_t     r_state;
    logic [Psize-1:0] r_pc;
    logic [Isize-1:0] r_instr;
    logic [Psize-1:0] r_instr_pc;
    logic             r_valid;
    logic             r_halted;

    logic             w_active;
    logic             w_load;
    logic             w_is_halt;
    logic             w_inc;
    logic [Psize-1:0] w_pc_next;
    logic             w_redirect;

    // Redirects are only honoured once fetch has been started.
    assign w_active  = (r_state != IDLE);
    assign w_load    = (r_state == RUN) && (!r_valid || bus.instr_ready);
    assign w_is_halt = (bus.pm_instr == HALT_WORD);
    assign w_inc     = w_load && !w_is_halt;

    pc_next #(
        .Psize (Psize)
    ) u_pc_next (
        .i_pc        (r_pc),
        .i_instr_pc  (r_instr_pc),
        .i_br_abs    (w_active && bus.br_abs),
        .i_br_rel    (w_active && bus.br_rel),
        .i_br_target (bus.br_target),
        .i_br_offset (bus.br_offset),
        .i_inc       (w_inc),
        .o_pc_next   (w_pc_next),
        .o_redirect  (w_redirect)
    );

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state    <= IDLE;
            r_pc       <= '0;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= RUN;
                    end
                end
                RUN, HALT: begin
                    if (w_redirect) begin
                        r_valid  <= 1'b0;
                        r_halted <= 1'b0;
                        r_state  <= RUN;
                    end else if (w_load) begin
                        r_instr    <= bus.pm_instr;
                        r_instr_pc <= r_pc;
                        r_valid    <= 1'b1;
                        if (w_is_halt) begin
                            r_state  <= HALT;
                            r_halted <= 1'b1;
                        end
                    end else if ((r_state == HALT) && bus.instr_ready) begin
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.pm_addr     = r_pc;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_valid;
    assign bus.halted      = r_halted;

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Directed self-checking bench for fetch_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;
    import picomips_pkg::*;

    logic        clk;
    logic        n_reset;
    logic [15:0] mem [32];
    int          n_cmp;
    int          n_err;

    fetch_ctrl_if #(.Psize(5), .Isize(16)) bus ();

    fetch_ctrl #(
        .Psize     (5),
        .Isize     (16),
        .HALT_WORD (16'hFFFF)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    assign bus.pm_instr = mem[bus.pm_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [15:0] e_instr, input logic [4:0] e_ipc,
                           input logic e_valid, input logic [4:0] e_addr, input logic e_halt);
        chk({tag, ".instr"},    {16'h0, bus.instr},       {16'h0, e_instr});
        chk({tag, ".instr_pc"}, {27'h0, bus.instr_pc},    {27'h0, e_ipc});
        chk({tag, ".valid"},    {31'h0, bus.instr_valid}, {31'h0, e_valid});
        chk({tag, ".pm_addr"},  {27'h0, bus.pm_addr},     {27'h0, e_addr});
        chk({tag, ".halted"},   {31'h0, bus.halted},      {31'h0, e_halt});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 32; i++) mem[i] = 16'(i);
        mem[6] = 16'hFFFF;

        n_reset         = 1'b0;
        bus.start       = 1'b0;
        bus.instr_ready = 1'b1;
        bus.br_abs      = 1'b0;
        bus.br_rel      = 1'b0;
        bus.br_target   = '0;
        bus.br_offset   = '0;
        step();
        step();
        n_reset = 1'b1;
        chk_out("reset", 16'h0, 5'd0, 1'b0, 5'd0, 1'b0);

        // Start: first instruction one cycle after entering RUN
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk_out("run_entry", 16'h0, 5'd0, 1'b0, 5'd0, 1'b0);
        step(); chk_out("fetch0", 16'h0000, 5'd0, 1'b1, 5'd1, 1'b0);
        step(); chk_out("fetch1", 16'h0001, 5'd1, 1'b1, 5'd2, 1'b0);
        step(); chk_out("fetch2", 16'h0002, 5'd2, 1'b1, 5'd3, 1'b0);

        // Backpressure holds IR and PC
        bus.instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out("stall", 16'h0002, 5'd2, 1'b1, 5'd3, 1'b0);
        end
        bus.instr_ready = 1'b1;
        step(); chk_out("release3", 16'h0003, 5'd3, 1'b1, 5'd4, 1'b0);
        step(); chk_out("fetch4",   16'h0004, 5'd4, 1'b1, 5'd5, 1'b0);
        step(); chk_out("fetch5",   16'h0005, 5'd5, 1'b1, 5'd6, 1'b0);

        // Absolute branch while HALT word is at pm_addr: redirect wins
        bus.br_abs = 1'b1; bus.br_target = 5'd20;
        step();
        bus.br_abs = 1'b0;
        chk_out("babs_bubble", 16'h0005, 5'd5, 1'b0, 5'd20, 1'b0);
        step(); chk_out("babs_tgt", 16'd20, 5'd20, 1'b1, 5'd21, 1'b0);

        bus.br_abs = 1'b1; bus.br_target = 5'd10;
        step();
        bus.br_abs = 1'b0;
        step(); chk_out("at10", 16'd10, 5'd10, 1'b1, 5'd11, 1'b0);

        // Relative branch with negative offset (-2)
        bus.br_rel = 1'b1; bus.br_offset = 5'b11110;
        step();
        bus.br_rel = 1'b0;
        chk_out("brel_neg", 16'd10, 5'd10, 1'b0, 5'd8, 1'b0);
        step(); chk_out("brel_tgt", 16'd8, 5'd8, 1'b1, 5'd9, 1'b0);

        // PC wrap 31 -> 0
        bus.br_abs = 1'b1; bus.br_target = 5'd30;
        step();
        bus.br_abs = 1'b0;
        step(); chk_out("at30", 16'd30, 5'd30, 1'b1, 5'd31, 1'b0);
        step(); chk_out("wrap", 16'd31, 5'd31, 1'b1, 5'd0, 1'b0);

        bus.br_abs = 1'b1; bus.br_target = 5'd30;
        step();
        bus.br_abs = 1'b0;
        step();
        bus.br_rel = 1'b1; bus.br_offset = 5'd3;
        step();
        bus.br_rel = 1'b0;
        chk("brel_wrap.pm_addr", {27'h0, bus.pm_addr}, 32'd1);

        // Both redirects: absolute wins
        bus.br_abs = 1'b1; bus.br_target = 5'd4;
        bus.br_rel = 1'b1; bus.br_offset = 5'd3;
        step();
        bus.br_abs = 1'b0; bus.br_rel = 1'b0;
        chk("abs_over_rel.pm_addr", {27'h0, bus.pm_addr}, 32'd4);
        step(); chk_out("fetch4b", 16'd4, 5'd4, 1'b1, 5'd5, 1'b0);
        step(); chk_out("fetch5b", 16'd5, 5'd5, 1'b1, 5'd6, 1'b0);

        // Halt word
        step(); chk_out("halt_load", 16'hFFFF, 5'd6, 1'b1, 5'd6, 1'b1);
        step(); chk_out("halt_drain", 16'hFFFF, 5'd6, 1'b0, 5'd6, 1'b1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk_out("halt_start", 16'hFFFF, 5'd6, 1'b0, 5'd6, 1'b1);
        bus.br_abs = 1'b1; bus.br_target = 5'd0;
        step();
        bus.br_abs = 1'b0;
        chk_out("halt_exit", 16'hFFFF, 5'd6, 1'b0, 5'd0, 1'b0);
        step(); chk_out("resume0", 16'd0, 5'd0, 1'b1, 5'd1, 1'b0);
        step(); chk_out("resume1", 16'd1, 5'd1, 1'b1, 5'd2, 1'b0);

        // Reset beats a simultaneous branch
        n_reset = 1'b0;
        bus.br_abs = 1'b1; bus.br_target = 5'd9;
        step();
        n_reset = 1'b1;
        chk_out("mid_reset", 16'h0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        bus.br_abs = 1'b0;
        chk_out("idle_nobranch", 16'h0, 5'd0, 1'b0, 5'd0, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step(); chk_out("restart0", 16'd0, 5'd0, 1'b1, 5'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fetch_ctrl
`default_nettype wire
